// File: rtl/qdma_tg_pkg.sv
// Shared definitions for the QDMA traffic-generator credit path: doorbell
// offsets, the credit FSM state type and the default index width.
package qdma_tg_pkg;

  localparam int IDX_W_DEFAULT = 16;

  localparam logic [19:0] C2H_PIDX_OFS  = 20'h18008;
  localparam logic [19:0] CMPT_CIDX_OFS = 20'h1800C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } credit_state_t;

  typedef logic [IDX_W_DEFAULT-1:0] ring_idx_t;

endpackage

// File: rtl/ring_occupancy.sv
// Registered modular distance head - tail on a ring of SIZE entries.
// With FREE set the output is the free space (SIZE-1 minus occupancy).
module ring_occupancy #(
  parameter int SIZE = 1024,
  parameter int W    = 16,
  parameter bit FREE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] head,
  input  logic [W-1:0] tail,
  output logic [W-1:0] count
);

  localparam logic [W:0]   SIZE_X = (W+1)'(SIZE);
  localparam logic [W-1:0] LAST   = W'(SIZE-1);

  logic [W:0] head_x;
  logic [W:0] tail_x;
  logic [W:0] diff;
  logic       diff_msb_unused;

  assign head_x = {1'b0, head};
  assign tail_x = {1'b0, tail};

  // Indices stay below SIZE, so the result always fits in W bits.
  always_comb begin
    if (head_x >= tail_x) diff = head_x - tail_x;
    else                  diff = head_x + SIZE_X - tail_x;
  end

  assign diff_msb_unused = diff[W];

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (FREE) count <= LAST - diff[W-1:0];
    else           count <= diff[W-1:0];
  end

endmodule

// File: rtl/c2h_desc_credit_tracker.sv
// Tracks C2H descriptor and completion ring credits from host doorbells and
// grants one packet per cycle. Optional counters: `define C2H_CREDIT_STATS_EN.
//
// state | meaning
// IDLE  | queue disabled, indices held at 0, doorbells ignored
// RUN   | granting while both descriptor and completion credit exist
// STALL | enabled but out of descriptors or completion slots
module c2h_desc_credit_tracker
  import qdma_tg_pkg::*;
#(
  parameter int DESC_RING_SIZE = 1024,
  parameter int CMPT_RING_SIZE = 1024,
  parameter int IDX_W          = IDX_W_DEFAULT
) (
  input  logic             user_clk_ip,
  input  logic             user_reset_ip,
  input  logic             cfg_en,
  input  logic             pidx_upd_valid,
  input  logic [IDX_W-1:0] pidx_upd_val,
  input  logic             cidx_upd_valid,
  input  logic [IDX_W-1:0] cidx_upd_val,
  input  logic             pkt_req_valid,
  output logic             pkt_req_ready,
  output logic [IDX_W-1:0] desc_cidx,
  output logic [IDX_W-1:0] cmpt_pidx,
  output logic [IDX_W-1:0] avail_desc,
  output logic [IDX_W-1:0] cmpt_space,
  output logic             upd_err,
  output logic [1:0]       state_o
`ifdef C2H_CREDIT_STATS_EN
  ,
  output logic [31:0]      stat_pkt_cnt,
  output logic [31:0]      stat_stall_cyc
`endif
);

  localparam logic [IDX_W:0]   DESC_SIZE_X = (IDX_W+1)'(DESC_RING_SIZE);
  localparam logic [IDX_W:0]   CMPT_SIZE_X = (IDX_W+1)'(CMPT_RING_SIZE);
  localparam logic [IDX_W-1:0] DESC_LAST   = IDX_W'(DESC_RING_SIZE-1);
  localparam logic [IDX_W-1:0] CMPT_LAST   = IDX_W'(CMPT_RING_SIZE-1);

  credit_state_t    state, state_nxt;
  logic [IDX_W-1:0] host_pidx, host_pidx_nxt;
  logic [IDX_W-1:0] host_cidx, host_cidx_nxt;
  logic [IDX_W-1:0] desc_cidx_nxt;
  logic [IDX_W-1:0] cmpt_pidx_nxt;
  logic             upd_err_nxt;
  logic             pidx_ok;
  logic             cidx_ok;
  logic             grant;
  logic             credit_ok;

  assign pidx_ok   = {1'b0, pidx_upd_val} < DESC_SIZE_X;
  assign cidx_ok   = {1'b0, cidx_upd_val} < CMPT_SIZE_X;
  assign credit_ok = (avail_desc != '0) && (cmpt_space != '0);

  // Ready comes only from registered state; the reset gate keeps a grant
  // from appearing to complete in a reset cycle.
  assign pkt_req_ready = !user_reset_ip && (state == RUN) && credit_ok;
  assign grant         = pkt_req_valid && pkt_req_ready;
  assign state_o       = state;

  always_comb begin
    state_nxt     = state;
    host_pidx_nxt = host_pidx;
    host_cidx_nxt = host_cidx;
    desc_cidx_nxt = desc_cidx;
    cmpt_pidx_nxt = cmpt_pidx;
    upd_err_nxt   = upd_err;
    case (state)
      IDLE: begin
        host_pidx_nxt = '0;
        host_cidx_nxt = '0;
        desc_cidx_nxt = '0;
        cmpt_pidx_nxt = '0;
        if (cfg_en) state_nxt = RUN;
      end
      RUN, STALL: begin
        if (pidx_upd_valid && !pidx_ok) upd_err_nxt = 1'b1;
        if (cidx_upd_valid && !cidx_ok) upd_err_nxt = 1'b1;
        if (!cfg_en) begin
          state_nxt     = IDLE;
          host_pidx_nxt = '0;
          host_cidx_nxt = '0;
          desc_cidx_nxt = '0;
          cmpt_pidx_nxt = '0;
        end else begin
          if (state == RUN && !credit_ok) state_nxt = STALL;
          if (state == STALL && credit_ok) state_nxt = RUN;
          if (pidx_upd_valid && pidx_ok) host_pidx_nxt = pidx_upd_val;
          if (cidx_upd_valid && cidx_ok) host_cidx_nxt = cidx_upd_val;
          if (grant) begin
            desc_cidx_nxt = (desc_cidx == DESC_LAST) ? '0 : desc_cidx + IDX_W'(1);
            cmpt_pidx_nxt = (cmpt_pidx == CMPT_LAST) ? '0 : cmpt_pidx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk_ip) begin
    if (user_reset_ip) begin
      state     <= IDLE;
      host_pidx <= '0;
      host_cidx <= '0;
      desc_cidx <= '0;
      cmpt_pidx <= '0;
      upd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      host_pidx <= host_pidx_nxt;
      host_cidx <= host_cidx_nxt;
      desc_cidx <= desc_cidx_nxt;
      cmpt_pidx <= cmpt_pidx_nxt;
      upd_err   <= upd_err_nxt;
    end
  end

  // Counts are computed from the next index values so they track the
  // index registers with no extra cycle of lag.
  ring_occupancy #(.SIZE(DESC_RING_SIZE), .W(IDX_W), .FREE(1'b0)) u_desc_occ (
    .clk   (user_clk_ip),
    .rst   (user_reset_ip),
    .head  (host_pidx_nxt),
    .tail  (desc_cidx_nxt),
    .count (avail_desc)
  );

  ring_occupancy #(.SIZE(CMPT_RING_SIZE), .W(IDX_W), .FREE(1'b1)) u_cmpt_occ (
    .clk   (user_clk_ip),
    .rst   (user_reset_ip),
    .head  (cmpt_pidx_nxt),
    .tail  (host_cidx_nxt),
    .count (cmpt_space)
  );

`ifdef C2H_CREDIT_STATS_EN
  always_ff @(posedge user_clk_ip) begin
    if (user_reset_ip || state_nxt == IDLE) begin
      stat_pkt_cnt   <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (grant && stat_pkt_cnt != 32'hFFFF_FFFF)
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      if (state == STALL && pkt_req_valid && stat_stall_cyc != 32'hFFFF_FFFF)
        stat_stall_cyc <= stat_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: doc/c2h_desc_credit_tracker.md
Name: c2h_desc_credit_tracker

Overview:
Downstream consumer of the CQ register-write monitor. Takes decoded host doorbell updates (C2H descriptor PIDX, completion-ring CIDX) and keeps per-queue ring occupancy. Grants one C2H packet per cycle to the traffic generator only when both a free descriptor and a free completion slot exist. Advances the hardware descriptor CIDX and completion PIDX on each grant.

Parameters:
DESC_RING_SIZE, 1024, C2H descriptor ring entries (2..65535, any integer)
CMPT_RING_SIZE, 1024, completion ring entries (2..65535, any integer)
IDX_W, 16, index/count width

Ports:
user_clk_ip  in  1  clock
user_reset_ip  in  1  synchronous active-high reset
cfg_en  in  1  queue enable
pidx_upd_valid  in  1  one-cycle strobe: host wrote C2H PIDX
pidx_upd_val  in  IDX_W  new host descriptor PIDX
cidx_upd_valid  in  1  one-cycle strobe: host wrote CMPT CIDX
cidx_upd_val  in  IDX_W  new host completion CIDX
pkt_req_valid  in  1  traffic generator requests one packet
pkt_req_ready  out  1  grant; packet consumed when valid&&ready
desc_cidx  out  IDX_W  hardware descriptor consume index
cmpt_pidx  out  IDX_W  hardware completion produce index
avail_desc  out  IDX_W  descriptors available
cmpt_space  out  IDX_W  free completion slots
upd_err  out  1  sticky: out-of-range update seen
state_o  out  2  FSM state

Behaviour:
- Reset: all indices, avail_desc, cmpt_space, upd_err = 0; pkt_req_ready = 0; state IDLE. Reset mid-operation drops any in-flight grant. No handshake completes in the reset cycle.
- Registers: host_pidx, host_cidx, desc_cidx, cmpt_pidx.
- Mod-diff: d(a,b) = a>=b ? a-b : a+SIZE-b, computed in IDX_W+1 bits.
- avail_desc = d(host_pidx, desc_cidx), range 0..DESC_RING_SIZE-1.
- cmpt_space = (CMPT_RING_SIZE-1) - d(cmpt_pidx, host_cidx). One slot is always kept empty.
- Both are registered and reflect updates 1 cycle after strobe or grant.
- Update valid: value < ring size, so register loads next edge. Update out of range: value ignored; upd_err set (cleared only by reset).
- Grant rules:
  - pkt_req_ready = (state==RUN) && avail_desc!=0 && cmpt_space!=0, from registered state only.
  - On valid&&ready: desc_cidx and cmpt_pidx each +1, wrapping SIZE-1 -> 0.
  - At most one grant per cycle. Count 1 plus a grant gives count 0 and ready low the next cycle. No over-grant.
- Simultaneous events: strobe and grant in the same cycle both apply. The next-cycle counts use the new host index and the incremented hardware index. pidx and cidx strobes together are independent.
- FSM:
  - IDLE -> RUN when cfg_en=1.
  - RUN -> STALL when a count is 0 (registered).
  - STALL -> RUN when both counts are nonzero.
  - RUN/STALL -> IDLE when cfg_en=0.
  - Entering IDLE clears all four indices, so a re-enabled queue starts at 0.
  - In IDLE, strobes are ignored and upd_err is unaffected.
- Encoding: IDLE=0, RUN=1, STALL=2.
- Host PIDX equal to desc_cidx means empty, not full.

Optional Feature:
C2H_CREDIT_STATS_EN
- Defined: adds stat_pkt_cnt[31:0] (grants) and stat_stall_cyc[31:0] (cycles in STALL with pkt_req_valid=1). Both saturate at 0xFFFFFFFF, are cleared by reset and on entering IDLE, and appear as output ports.
- Undefined: the ports and logic are absent. Grant behaviour is identical either way.

Decomposition:
- Package qdma_tg_pkg holds:
  - IDX_W default
  - doorbell offsets C2H_PIDX_OFS=20'h18008, CMPT_CIDX_OFS=20'h1800C
  - typedef enum logic[1:0] credit_state_t {IDLE, RUN, STALL}
  - typedef logic[IDX_W-1:0] ring_idx_t
- Sub-module ring_occupancy (params SIZE, W; inputs head, tail; output registered count) is instantiated twice.

Test Plan:
- Reset, cfg_en=1, pidx_upd_val=8, pkt_req_valid held high -> exactly 8 grants on consecutive cycles; desc_cidx=8; avail_desc=0; state STALL; ready low.
- DESC_RING_SIZE=1000; pidx 990 then, after 990 grants, pidx 5 -> 15 more grants; desc_cidx wraps 999->0 and ends at 5.
- CMPT_RING_SIZE=4, pidx 100, no cidx update -> 3 grants then stall; cidx_upd_val=2 -> 2 more grants; cmpt_pidx=1 (5 mod 4).
- pidx strobe (value 3) in the same cycle as a grant with avail_desc=1 -> next cycle avail_desc=2, desc_cidx=1, no lost or extra grant.
- pidx_upd_val=1024 with size 1024 -> upd_err=1, host_pidx unchanged; later pidx 4 accepted; upd_err stays 1 until reset.
- cfg_en deasserted mid-stream after 5 grants -> IDLE, indices 0, ready 0; re-enable, pidx 2 -> 2 grants. With C2H_CREDIT_STATS_EN: stat_pkt_cnt=2.
